// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM states,
// response codes and bus widths.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;
    localparam int APB_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] APB_RSP_OK      = 2'b00;
    localparam logic [1:0] APB_RSP_SLVERR  = 2'b01;
    localparam logic [1:0] APB_RSP_TIMEOUT = 2'b10;

    // Reads drive no byte lanes on the bus.
    function automatic logic [APB_STRB_W-1:0] apb_strb_sel(
        input logic                  write,
        input logic [APB_STRB_W-1:0] strb
    );
        if (write) begin
            return strb;
        end else begin
            return {APB_STRB_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating 16-bit wait counter with synchronous clear and a registered
// terminal-count flag that is high once LIMIT-1 wait cycles have elapsed.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [APB_CNT_W-1:0] TC_VAL = APB_CNT_W'(LIMIT - 1);

    logic [APB_CNT_W-1:0] count_q;
    logic [APB_CNT_W-1:0] count_d;
    logic                 tc_q;
    logic                 tc_d;

    // Next count: clear wins, otherwise increment and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {APB_CNT_W{1'b0}};
        end else if (en_i && (count_q != {APB_CNT_W{1'b1}})) begin
            count_d = count_q + {{(APB_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        tc_d = (count_d >= TC_VAL);
    end

    // Counter and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {APB_CNT_W{1'b0}};
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge with optional
// wait-state timeout. All bus and response outputs come straight from flops.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_EN     = 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    input  logic [APB_STRB_W-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_STRB_W-1:0] pstrb,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_state_e            state_q, state_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic                  psel_q, penable_q, cmd_ready_q, rsp_valid_q;
    logic                  cnt_clr_s;
    logic                  cnt_en_s;
    logic                  cnt_tc_s;
    logic                  timeout_s;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i (pclk),
        .rst_i (preset),
        .clr_i (cnt_clr_s),
        .en_i  (cnt_en_s),
        .tc_o  (cnt_tc_s)
    );

    assign timeout_s = (TIMEOUT_EN != 0) && cnt_tc_s;

    // Next-state, bus capture and response capture.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_SETUP;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    pstrb_d   = apb_strb_sel(cmd_write, cmd_strb);
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave beats a timeout landing on the same edge.
                if (pready) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = pwrite_q ? {APB_DATA_W{1'b0}} : prdata;
                    rsp_err_d   = pslverr ? APB_RSP_SLVERR : APB_RSP_OK;
                end else if (timeout_s) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = {APB_DATA_W{1'b0}};
                    rsp_err_d   = APB_RSP_TIMEOUT;
                end else begin
                    state_d  = ST_ACCESS;
                    cnt_en_s = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bus and response registers; strobes decoded from the next state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= {APB_ADDR_W{1'b0}};
            pwdata_q    <= {APB_DATA_W{1'b0}};
            pstrb_q     <= {APB_STRB_W{1'b0}};
            pwrite_q    <= 1'b0;
            rsp_rdata_q <= {APB_DATA_W{1'b0}};
            rsp_err_q   <= APB_RSP_OK;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pwrite_q    <= pwrite_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed, table-driven bench for apb_master_bridge with a 4-cycle timeout,
// a reactive APB slave and a passive APB protocol monitor.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        preset, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, paddr, pwdata, prdata;
    logic [3:0]  cmd_strb, pstrb;
    logic [1:0]  rsp_err;
    logic        psel, penable, pwrite, pready, pslverr;

    int checks = 0;
    int errors = 0;
    int apb_err = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_EN     (1)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        slverr;
        logic        slverr_wait;
        logic [31:0] rdata;
        int          hold;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Passive APB monitor; compares the cycle just ended with the one before.
    logic        mon_on = 1'b0;
    logic        p_sel, p_en, p_rdy, p_rst, p_wr;
    logic [31:0] p_addr, p_wd;
    logic [3:0]  p_st;
    always @(posedge pclk) begin
        if (mon_on && !p_rst) begin
            if (penable && !psel) apb_err++;
            if (!p_sel && psel && penable) apb_err++;
            if (p_sel && !p_en && !(psel && penable)) apb_err++;
            if (p_sel && p_rdy && p_en && psel) apb_err++;
            if (p_sel && psel && ((paddr !== p_addr) || (pwrite !== p_wr) ||
                                  (pwdata !== p_wd) || (pstrb !== p_st))) apb_err++;
        end
        if (preset === 1'b1) mon_on <= 1'b1;
        p_sel  <= psel;   p_en <= penable; p_rdy <= pready; p_rst <= preset;
        p_addr <= paddr;  p_wr <= pwrite;  p_wd  <= pwdata; p_st  <= pstrb;
    end

    // Runs one transfer; entered and left at a falling edge in IDLE.
    task automatic run_txn(input vec_t v, input int idx);
        int          acc;
        bit          done;
        logic [3:0]  exp_strb;
        string       tag;
        tag      = $sformatf("v%0d", idx);
        exp_strb = v.write ? v.strb : 4'h0;
        chk({tag, "_cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'h0; cmd_strb = 4'hF;
        chk({tag, "_setup_psel"}, {30'd0, psel, penable}, 32'd2);
        chk({tag, "_setup_paddr"}, paddr, v.addr);
        chk({tag, "_setup_pstrb"}, {28'd0, pstrb}, {28'd0, exp_strb});
        chk({tag, "_setup_ready"}, {31'd0, cmd_ready}, 32'd0);
        acc  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (psel && penable) begin
                acc++;
                chk({tag, "_acc_paddr"}, paddr, v.addr);
                chk({tag, "_acc_pwdata"}, pwdata, v.wdata);
                chk({tag, "_acc_ctl"}, {27'd0, pwrite, pstrb}, {27'd0, v.write, exp_strb});
                pready  = (acc == v.waits + 1);
                pslverr = pready ? v.slverr : v.slverr_wait;
                prdata  = pready ? v.rdata : 32'hDEAD_BEEF;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_bound: transfer did not finish, got %0d ACCESS cycles", tag, acc);
        end
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_0BAD;
        chk({tag, "_acc_cycles"}, acc, v.exp_acc);
        chk({tag, "_rsp_valid"}, {29'd0, rsp_valid, psel, cmd_ready}, 32'd4);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_err"}, {30'd0, rsp_err}, {30'd0, v.exp_err});
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0BAD;
            @(negedge pclk);
            chk({tag, "_hold_flags"}, {29'd0, rsp_valid, psel, cmd_ready}, 32'd4);
            chk({tag, "_hold_rdata"}, rsp_rdata, v.exp_rdata);
            chk({tag, "_hold_err"}, {30'd0, rsp_err}, {30'd0, v.exp_err});
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk({tag, "_done_flags"}, {29'd0, rsp_valid, psel, cmd_ready}, 32'd1);
    endtask

    initial begin
        //           wr    addr          wdata         strb  w   se    sew   prdata        hold acc exp_rdata     err
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0,  1'b0, 1'b0, 32'h1111_1111, 0, 1, 32'h0,         2'b00};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h1234_5678, 4'hF, 3,  1'b0, 1'b0, 32'h0000_0061, 0, 4, 32'h0000_0061, 2'b00};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2,  1'b1, 1'b1, 32'h0000_1234, 0, 3, 32'h0000_1234, 2'b01};
        vecs[3] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2,  1'b0, 1'b1, 32'h0000_5678, 0, 3, 32'h0000_5678, 2'b00};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 99, 1'b0, 1'b0, 32'h7777_7777, 0, 4, 32'h0,         2'b10};
        vecs[5] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 3,  1'b0, 1'b0, 32'hCAFE_0001, 0, 4, 32'hCAFE_0001, 2'b00};
        vecs[6] = '{1'b1, 32'h0000_0028, 32'h0F0F_F0F0, 4'h9, 99, 1'b0, 1'b0, 32'h0,         0, 4, 32'h0,         2'b10};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h0000_00AB, 4'h3, 1,  1'b1, 1'b0, 32'h5555_5555, 5, 2, 32'h0,         2'b01};
        vecs[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1,  1'b0, 1'b0, 32'hFFFF_FFFF, 5, 2, 32'hFFFF_FFFF, 2'b00};
        vecs[9] = '{1'b1, 32'h0000_0030, 32'h0000_BEEF, 4'h5, 1,  1'b0, 1'b0, 32'hAAAA_AAAA, 0, 2, 32'h0,         2'b00};

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_strb = 4'h0; rsp_ready = 1'b0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_ctl", {28'd0, psel, penable, pwrite, rsp_valid}, 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb_err", {26'd0, pstrb, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset while a read is stalled in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0044; cmd_strb = 4'hF;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        chk("mid_access", {30'd0, psel, penable}, 32'd3);
        preset = 1'b1;
        @(negedge pclk);
        chk("rst_acc_ctl", {28'd0, psel, penable, pwrite, rsp_valid}, 32'd0);
        chk("rst_acc_paddr", paddr, 32'h0);
        chk("rst_acc_pstrb", {28'd0, pstrb}, 32'd0);
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_acc_after", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        run_txn(vecs[1], 10);

        // Reset while a response is pending.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0048;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        pready = 1'b1; prdata = 32'h0000_0099;
        @(negedge pclk);
        pready = 1'b0;
        chk("pre_rst_resp", {31'd0, rsp_valid}, 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_resp_rdata", rsp_rdata, 32'h0);
        @(negedge pclk);
        chk("rst_resp_after", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        run_txn(vecs[0], 11);

        chk("apb_protocol", apb_err, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: consecutive ACCESS cycles with pready=0 before abort; legal range 2..65535.
REQ-002 Parameter TIMEOUT_EN, default 1: 1 enables abort on timeout, 0 waits forever.
REQ-003 pclk  in  1  sole clock; all logic on rising edge.
REQ-004 preset  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a pclk edge.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  transfer address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_strb  in  4  write byte strobes.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a pclk edge.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-014 rsp_err  out  2  00=OK, 01=SLVERR, 10=TIMEOUT, 11 never driven.
REQ-015 psel, penable, pwrite  out  1 each  APB control.
REQ-016 paddr  out  32; pwdata  out  32; pstrb  out  4  APB address/data/strobe.
REQ-017 prdata  in  32; pready  in  1; pslverr  in  1  APB slave response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, RESP; one transfer in flight, no buffering.
REQ-019 cmd_ready SHALL be 1 only in IDLE (registered state decode, no combinational path from cmd_valid).
REQ-020 Accept in IDLE -> SETUP: register paddr, pwrite, pwdata; pstrb=cmd_strb for writes, 4'h0 for reads.
REQ-021 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb stable from SETUP through final ACCESS cycle.
REQ-023 ACCESS with pready=1 -> RESP; capture rsp_rdata=prdata (reads only, else 0), rsp_err=pslverr?01:00.
REQ-024 pslverr and prdata sampled only on the pready=1 ACCESS cycle; ignored otherwise.
REQ-025 Wait counter (16 bit) clears on SETUP entry, increments each ACCESS cycle with pready=0.
REQ-026 TIMEOUT_EN=1 and counter reaching TIMEOUT_CYCLES at a pready=0 edge -> RESP with rsp_err=10, rsp_rdata=0; pready=1 on that same edge takes priority (normal completion).
REQ-027 TIMEOUT_EN=0: counter saturates at 16'hFFFF, no abort.
REQ-028 psel=penable=0 in IDLE and RESP; paddr/pwrite/pwdata/pstrb hold last value (never X).
REQ-029 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; handshake -> IDLE.
REQ-030 Latency zero-wait slave: accept edge N; SETUP cycle N+1; ACCESS N+2; rsp_valid from N+3; next cmd_ready at earliest N+4 with rsp_ready=1.
REQ-031 Back-to-back APB transfers SHALL have at least two idle-bus cycles (RESP, IDLE) between them.
REQ-032 No X/Z SHALL appear on any output after the first reset edge.

Reset
REQ-033 preset=1 at pclk edge: state=IDLE, counter=0, psel=penable=pwrite=0, paddr=pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=00; cmd_ready=1 first cycle after reset deasserts.
REQ-034 Reset mid-SETUP/ACCESS/RESP SHALL abandon the transfer with no response produced; psel low on the edge after reset assertion.

Structure
REQ-035 Shared package apb_pkg SHALL hold state enum, rsp_err codes (APB_RSP_OK/SLVERR/TIMEOUT), and bus width constants.
REQ-036 One sub-module apb_timeout_cnt (clear, enable, saturate, terminal-count flag); everything else in one module.

Verification
REQ-037 Write addr 32'h0000_0010, wdata 32'hA5A5_5A5A, strb 4'hF, pready tied 1 -> psel 2 cycles, penable 1 cycle, rsp_valid at N+3, rsp_err=00, rsp_rdata=0.
REQ-038 Read addr 32'h0000_0004, pready low 3 ACCESS cycles then high with prdata 32'h0000_0061 -> pstrb=0, signals stable 4 ACCESS cycles, rsp_rdata=32'h61, rsp_err=00.
REQ-039 Read with pslverr=1 on pready cycle -> rsp_err=01; pslverr=1 on earlier wait cycles ignored.
REQ-040 TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles, rsp_err=10, rsp_rdata=0; variant with pready=1 on 4th cycle -> rsp_err=00.
REQ-041 rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, cmd_ready=0, new cmd_valid not accepted until handshake.
REQ-042 preset asserted during ACCESS -> all outputs at reset values next cycle, no rsp_valid; a following read completes normally; passive APB protocol checker reports no APB_ERROR throughout all scenarios.
